pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/mips_pkg.sv | 25 ++
 rtl/next_pc_calc.sv | 35 +++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the PC sequencer: FSM state encoding, decoder path codes,
// and the immediate sign-extension helper used by branch target arithmetic.
// Pure declarations; no latency or backpressure of its own.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_NEXT,
    ST_HALT
  } state_t;

  localparam logic [3:0] PATH_BRANCH = 4'd4;
  localparam logic [3:0] PATH_J      = 4'd5;
  localparam logic [3:0] PATH_JAL    = 4'd6;
  localparam logic [3:0] PATH_JR     = 4'd8;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump/jal target, jr register target, taken branch, or pc+1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
// Ports: i_pc current pc, i_ir_low latched IR[25:0], i_path/i_jump/i_branch_taken
//        latched decode fields, i_reg_addr jr target, o_next_pc selected next pc.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_ir_low,
  input  logic [3:0]  i_path,
  input  logic        i_jump,
  input  logic        i_branch_taken,
  input  logic [31:0] i_reg_addr,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_seq_pc;

  // All sums are 32 bits wide, so overflow wraps modulo 2^32.
  assign w_seq_pc = i_pc + 32'd1;

  always_comb begin
    o_next_pc = w_seq_pc;
    if (i_jump && (i_path == PATH_J || i_path == PATH_JAL)) begin
      // Region-relative jump: keep the top 6 bits of the current pc.
      o_next_pc = {i_pc[31:26], i_ir_low};
    end else if (i_jump && i_path == PATH_JR) begin
      o_next_pc = i_reg_addr;
    end else if (i_path == PATH_BRANCH && i_branch_taken) begin
      o_next_pc = w_seq_pc + sext16(i_ir_low[15:0]);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB/NEXT loop with halt detection.
// Latency: 5 cycles per instruction without stalls; NEXT always takes one cycle.
// Backpressure: stall holds FETCH, DECODE, EXEC and WB; start only honoured in IDLE.
// Ports: clk/rst (sync, active-high), start, stall, instr, path_index, jump,
//        branch_taken, reg_addr in; pc, fetch_en/decode_en/exec_en/wb_en,
//        pc_update, busy, halted out.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT   = 32'd255,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic [3:0]  path_index,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] reg_addr,
  output logic [31:0] pc,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        pc_update,
  output logic        busy,
  output logic        halted
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [3:0]  r_path;
  logic        r_jump;
  logic        r_taken;
  logic [31:0] r_reg_addr;
  logic [31:0] w_next_pc;
  logic        w_over_limit;

  next_pc_calc u_next_pc_calc (
    .i_pc           (r_pc),
    .i_ir_low       (r_ir[25:0]),
    .i_path         (r_path),
    .i_jump         (r_jump),
    .i_branch_taken (r_taken),
    .i_reg_addr     (r_reg_addr),
    .o_next_pc      (w_next_pc)
  );

  assign w_over_limit = (w_next_pc > PC_LIMIT);
  assign pc           = r_pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_FETCH;
      ST_FETCH:  if (!stall) w_state_nxt = ST_DECODE;
      // The halt word is recognised from the latched IR, so pc never advances.
      ST_DECODE: if (!stall) w_state_nxt = (r_ir == HALT_INSTR) ? ST_HALT : ST_EXEC;
      ST_EXEC:   if (!stall) w_state_nxt = ST_WB;
      ST_WB:     if (!stall) w_state_nxt = ST_NEXT;
      ST_NEXT:   w_state_nxt = w_over_limit ? ST_HALT : ST_FETCH;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    wb_en     = 1'b0;
    pc_update = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    case (r_state)
      ST_FETCH:  begin fetch_en  = 1'b1; busy = 1'b1; end
      ST_DECODE: begin decode_en = 1'b1; busy = 1'b1; end
      ST_EXEC:   begin exec_en   = 1'b1; busy = 1'b1; end
      ST_WB:     begin wb_en     = 1'b1; busy = 1'b1; end
      ST_NEXT:   begin pc_update = 1'b1; busy = 1'b1; end
      ST_HALT:   halted = 1'b1;
      default:   ;
    endcase
  end

  // Datapath: IR captured on leaving FETCH, decode fields on leaving EXEC,
  // pc loaded in NEXT even when the new value is out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= PC_RESET;
      r_ir       <= 32'd0;
      r_path     <= 4'd0;
      r_jump     <= 1'b0;
      r_taken    <= 1'b0;
      r_reg_addr <= 32'd0;
    end else begin
      if (r_state == ST_FETCH && !stall) r_ir <= instr;
      if (r_state == ST_EXEC && !stall) begin
        r_path     <= path_index;
        r_jump     <= jump;
        r_taken    <= branch_taken;
        r_reg_addr <= reg_addr;
      end
      if (r_state == ST_NEXT) r_pc <= w_next_pc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// instruction streams compared against a next-PC reference model.
module tb_pc_sequencer;

  localparam logic [31:0] PC_RESET   = 32'h0000_0000;
  localparam logic [31:0] PC_LIMIT   = 32'd255;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [3:0]  path_index = 4'd0;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] reg_addr = 32'd0;
  logic [31:0] pc;
  logic        fetch_en, decode_en, exec_en, wb_en, pc_update, busy, halted;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc = PC_RESET;
  bit          m_halted = 1'b0;

  pc_sequencer #(
    .PC_RESET   (PC_RESET),
    .PC_LIMIT   (PC_LIMIT),
    .HALT_INSTR (HALT_INSTR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .instr        (instr),
    .path_index   (path_index),
    .jump         (jump),
    .branch_taken (branch_taken),
    .reg_addr     (reg_addr),
    .pc           (pc),
    .fetch_en     (fetch_en),
    .decode_en    (decode_en),
    .exec_en      (exec_en),
    .wb_en        (wb_en),
    .pc_update    (pc_update),
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required the bench to finish");
    $fatal(1, "timeout");
  end

  // Reference next PC straight from the instruction-set rules, using wide integers.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ir,
                                             input int pth, input bit j, input bit t,
                                             input logic [31:0] ra);
    longint off;
    if (j && (pth == 5 || pth == 6)) return (p & 32'hFC00_0000) | (ir & 32'h03FF_FFFF);
    if (j && pth == 8) return ra;
    if (pth == 4 && t) begin
      off = longint'(ir & 32'h0000_FFFF);
      if (off >= 32768) off = off - 65536;
      return 32'(longint'(p) + 64'sd1 + off);
    end
    return 32'(longint'(p) + 64'sd1);
  endfunction

  task automatic apply_reset;
    rst = 1'b1; start = 1'b1; stall = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    m_pc = PC_RESET; m_halted = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one instruction starting in FETCH, with sf/sd/se/sw stall cycles per stage.
  // Fields are only valid in the stage that latches them; garbage elsewhere.
  task automatic run_instr(input logic [31:0] ins, input int pth, input bit jmp, input bit tkn,
                           input logic [31:0] ra, input int sf, input int sd, input int se,
                           input int sw, output int cycles);
    int          q[$];
    int          stg;
    logic [3:0]  exp_en;
    logic [31:0] nxt;
    bit          hlt;
    hlt = (ins == HALT_INSTR);
    repeat (sf + 1) q.push_back(1);
    repeat (sd + 1) q.push_back(2);
    if (!hlt) begin
      repeat (se + 1) q.push_back(3);
      repeat (sw + 1) q.push_back(4);
      q.push_back(5);
    end
    nxt = hlt ? m_pc : model_next(m_pc, ins, pth, jmp, tkn, ra);
    for (int k = 0; k < q.size(); k++) begin
      stg = q[k];
      exp_en = (stg <= 4) ? (4'b1000 >> (stg - 1)) : 4'b0000;
      n_tests++;
      if ({fetch_en, decode_en, exec_en, wb_en} !== exp_en || busy !== 1'b1 || halted !== 1'b0 ||
          pc_update !== (stg == 5) || pc !== m_pc) begin
        n_fail++;
        $display("FAIL stage_seq k=%0d: en=%b busy=%b halted=%b upd=%b pc=%h, want en=%b busy=1 halted=0 upd=%0d pc=%h",
                 k, {fetch_en, decode_en, exec_en, wb_en}, busy, halted, pc_update, pc,
                 exp_en, (stg == 5), m_pc);
      end
      instr = (stg == 1) ? ins : $urandom;
      if (stg == 3) begin
        path_index = 4'(pth); jump = jmp; branch_taken = tkn; reg_addr = ra;
      end else begin
        path_index = 4'($urandom); jump = 1'($urandom); branch_taken = 1'($urandom);
        reg_addr = $urandom;
      end
      stall = (stg == 5) ? 1'($urandom) : (k + 1 < q.size() && q[k + 1] == stg);
      start = 1'($urandom);
      @(negedge clk);
    end
    stall = 1'b0; start = 1'b0;
    cycles = q.size();
    n_tests++;
    if (pc !== nxt) begin
      n_fail++;
      $display("FAIL next_pc: pc=%h, want %h (ir=%h path=%0d jump=%0d taken=%0d reg=%h)",
               pc, nxt, ins, pth, jmp, tkn, ra);
    end
    m_pc = nxt;
    m_halted = hlt || (nxt > PC_LIMIT);
    n_tests++;
    if (m_halted) begin
      if (halted !== 1'b1 || busy !== 1'b0 || {fetch_en, decode_en, exec_en, wb_en, pc_update} !== 5'b0) begin
        n_fail++;
        $display("FAIL halt_entry: halted=%b busy=%b en=%b upd=%b, want halted=1 busy=0 en=0000 upd=0",
                 halted, busy, {fetch_en, decode_en, exec_en, wb_en}, pc_update);
      end
    end else if (fetch_en !== 1'b1 || busy !== 1'b1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_back: fetch_en=%b busy=%b halted=%b, want 1 1 0", fetch_en, busy, halted);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({fetch_en, decode_en, exec_en, wb_en, pc_update, busy, halted} !== 7'b0 || pc !== PC_RESET) begin
      n_fail++;
      $display("FAIL reset_state: outs=%b pc=%h, want outs=0000000 pc=%h",
               {fetch_en, decode_en, exec_en, wb_en, pc_update, busy, halted}, pc, PC_RESET);
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || fetch_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b fetch_en=%b, want 0 0", busy, fetch_en);
    end
    m_pc = PC_RESET;
  endtask

  task automatic test_sequential;
    int c;
    do_start();
    for (int i = 1; i <= 2; i++) begin
      run_instr(32'h0, 0, 1'b0, 1'b0, 32'h0, 0, 0, 0, 0, c);
      n_tests++;
      if (c != 5 || pc !== 32'(i)) begin
        n_fail++;
        $display("FAIL sequential: cycles=%0d pc=%h, want cycles=5 pc=%h", c, pc, 32'(i));
      end
    end
  endtask

  task automatic test_jump;
    int c;
    run_instr(32'h0800_0010, 5, 1'b1, 1'b0, 32'h0, 0, 0, 0, 0, c);
    run_instr(32'h0800_0040, 5, 1'b1, 1'b0, 32'h0, 0, 0, 0, 0, c);
    n_tests++;
    if (pc !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL jump_j: pc=%h, want 00000040", pc);
    end
  endtask

  task automatic test_branch;
    int c;
    run_instr(32'h0C00_000A, 6, 1'b1, 1'b0, 32'h0, 0, 0, 0, 0, c);
    run_instr(32'h0000_FFFE, 4, 1'b0, 1'b1, 32'h0, 0, 0, 0, 0, c);
    n_tests++;
    if (pc !== 32'd9) begin
      n_fail++;
      $display("FAIL branch_taken: pc=%0d, want 9", pc);
    end
    run_instr(32'h0800_000A, 5, 1'b1, 1'b0, 32'h0, 0, 0, 0, 0, c);
    run_instr(32'h0000_FFFE, 4, 1'b0, 1'b0, 32'h0, 0, 0, 0, 0, c);
    n_tests++;
    if (pc !== 32'd11) begin
      n_fail++;
      $display("FAIL branch_not_taken: pc=%0d, want 11", pc);
    end
  endtask

  task automatic test_stall;
    int c;
    run_instr(32'h0, 0, 1'b0, 1'b0, 32'h0, 0, 0, 3, 0, c);
    n_tests++;
    if (c != 8) begin
      n_fail++;
      $display("FAIL exec_stall_cycles: cycles=%0d, want 8", c);
    end
    run_instr(32'h0, 0, 1'b0, 1'b0, 32'h0, 2, 1, 0, 2, c);
    n_tests++;
    if (c != 10) begin
      n_fail++;
      $display("FAIL mixed_stall_cycles: cycles=%0d, want 10", c);
    end
  endtask

  task automatic test_halt;
    int          c;
    logic [31:0] held;
    held = m_pc;
    run_instr(HALT_INSTR, 0, 1'b0, 1'b0, 32'h0, 0, 1, 0, 0, c);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== held) begin
      n_fail++;
      $display("FAIL halt_sticky: halted=%b busy=%b pc=%h, want 1 0 %h", halted, busy, pc, held);
    end
    apply_reset();
    n_tests++;
    if (halted !== 1'b0 || busy !== 1'b0 || pc !== PC_RESET) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%b busy=%b pc=%h, want 0 0 %h", halted, busy, pc, PC_RESET);
    end
  endtask

  task automatic test_reset_mid;
    int c;
    do_start();
    run_instr(32'h0800_0020, 5, 1'b1, 1'b0, 32'h0, 0, 0, 0, 0, c);
    stall = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (wb_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_wb: wb_en=%b, want 1", wb_en);
    end
    rst = 1'b1; stall = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    m_pc = PC_RESET; m_halted = 1'b0;
    n_tests++;
    if ({fetch_en, decode_en, exec_en, wb_en, pc_update, busy, halted} !== 7'b0 || pc !== PC_RESET) begin
      n_fail++;
      $display("FAIL reset_in_wb: outs=%b pc=%h, want outs=0000000 pc=%h",
               {fetch_en, decode_en, exec_en, wb_en, pc_update, busy, halted}, pc, PC_RESET);
    end
  endtask

  task automatic test_jr_limit;
    int c;
    do_start();
    run_instr(32'h0, 8, 1'b1, 1'b0, 32'd300, 0, 0, 0, 0, c);
    n_tests++;
    if (pc !== 32'd300 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL jr_over_limit: pc=%0d halted=%b, want 300 1", pc, halted);
    end
    apply_reset();
  endtask

  task automatic test_random;
    int          c, kind, pth;
    bit          jmp, tkn;
    logic [31:0] ins, ra;
    do_start();
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      ins = $urandom & 32'h7FFF_FFFF;
      pth = $urandom_range(0, 15); jmp = 1'($urandom); tkn = 1'($urandom);
      ra = $urandom_range(0, 270);
      case (kind)
        0, 1: begin pth = ($urandom_range(0, 1) != 0) ? 5 : 6; jmp = 1'b1;
                ins = {6'($urandom), 18'd0, 8'($urandom)}; end
        2, 3: begin pth = 8; jmp = 1'b1; end
        4, 5, 6: begin pth = 4; jmp = 1'b0;
                ins = {16'($urandom), 16'(32'($urandom_range(0, 60)) - 32'd30)}; end
        7: ins = HALT_INSTR;
        default: ;
      endcase
      run_instr(ins, pth, jmp, tkn, ra, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2), c);
      if (m_halted) begin
        apply_reset();
        do_start();
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_stall();
    test_halt();
    test_reset_mid();
    test_jr_limit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
